// File: rtl/register_pending_table_if.sv
// Bus bundle for register_pending_table: set/clear requests, lookup ports and
// the status outputs. The table drives the slave side.
interface register_pending_table_if #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 5,
  parameter int READ_PORTS = 2
);
  logic                          set_enable;
  logic [DEPTH-1:0]              set_index;
  logic [WIDTH-1:0]              set_tag;
  logic                          clear_enable;
  logic [DEPTH-1:0]              clear_index;
  logic [WIDTH-1:0]              clear_tag;
  logic [READ_PORTS*DEPTH-1:0]   read_index;
  logic [READ_PORTS-1:0]         read_pending;
  logic [READ_PORTS*WIDTH-1:0]   read_tag;
  logic                          set_accept;
  logic [DEPTH:0]                pending_count;
  logic                          full;

  modport master (
    output set_enable, set_index, set_tag,
    output clear_enable, clear_index, clear_tag,
    output read_index,
    input  read_pending, read_tag, set_accept, pending_count, full
  );

  modport slave (
    input  set_enable, set_index, set_tag,
    input  clear_enable, clear_index, clear_tag,
    input  read_index,
    output read_pending, read_tag, set_accept, pending_count, full
  );
endinterface

// File: rtl/register_pending_table.sv
// register_pending_table: scoreboard of 2**DEPTH entries, each holding a pending
// bit and a WIDTH-bit tag. Entry 0 never becomes pending. A clear only retires an
// entry when its tag matches the stored one, so stale completions are dropped.
// At most MAX_PENDING entries may be pending at once.
// Optional feature: define REGISTER_PENDING_BYPASS_EN to let the lookup ports see
// this cycle's accepted set / valid clear; otherwise they show registered state.
module register_pending_table #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 5,
  parameter int READ_PORTS  = 2,
  parameter int MAX_PENDING = 4
) (
  input logic clk,
  input logic reset,
  register_pending_table_if.slave bus
);
  localparam int ENTRIES = 1 << DEPTH;

  logic                 pending_reg [ENTRIES];
  logic [WIDTH-1:0]     tag_reg     [ENTRIES];
  logic [DEPTH:0]       count_reg;
  logic [DEPTH:0]       count_next;

  logic                 full_int;
  logic                 set_hits_pending;
  logic                 set_accept_int;
  logic                 set_is_new;
  logic                 clear_valid;

  logic [READ_PORTS-1:0]       read_pending_vec;
  logic [READ_PORTS*WIDTH-1:0] read_tag_vec;

  // Request qualification. Index 0 is excluded from both set and clear here,
  // which keeps entry 0 permanently idle with tag 0. A clear that collides with
  // an accepted set on the same entry is dropped so the set wins and the count
  // does not move (the entry was already pending, so the set is not "new").
  always_comb begin
    full_int         = (count_reg >= (DEPTH+1)'(MAX_PENDING));
    set_hits_pending = pending_reg[bus.set_index];
    set_accept_int   = bus.set_enable && (bus.set_index != '0) &&
                       (!full_int || set_hits_pending);
    set_is_new       = set_accept_int && !set_hits_pending;
    clear_valid      = bus.clear_enable && (bus.clear_index != '0) &&
                       pending_reg[bus.clear_index] &&
                       (tag_reg[bus.clear_index] == bus.clear_tag) &&
                       !(set_accept_int && (bus.set_index == bus.clear_index));
    count_next       = count_reg + {{DEPTH{1'b0}}, set_is_new}
                                 - {{DEPTH{1'b0}}, clear_valid};
  end

  // Pending-count register; a new set is only accepted below MAX_PENDING and a
  // clear needs a pending entry, so the count stays within 0..MAX_PENDING.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    logic set_hit;
    logic clear_hit;

    assign set_hit   = set_accept_int && (bus.set_index == DEPTH'(gi));
    assign clear_hit = clear_valid && (bus.clear_index == DEPTH'(gi));

    // Per-entry state: set writes pending and tag, clear drops pending only.
    always_ff @(posedge clk) begin
      if (reset) begin
        pending_reg[gi] <= 1'b0;
        tag_reg[gi]     <= '0;
      end else if (set_hit) begin
        pending_reg[gi] <= 1'b1;
        tag_reg[gi]     <= bus.set_tag;
      end else if (clear_hit) begin
        pending_reg[gi] <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < READ_PORTS; gi++) begin : g_read
    logic [DEPTH-1:0] idx;
    logic             pend;
    logic [WIDTH-1:0] tag;

    assign idx = bus.read_index[gi*DEPTH +: DEPTH];

    // Lookup: registered state, optionally overridden by this cycle's updates.
    always_comb begin
      pend = pending_reg[idx];
      tag  = tag_reg[idx];
`ifdef REGISTER_PENDING_BYPASS_EN
      if (clear_valid && (bus.clear_index == idx)) begin
        pend = 1'b0;
      end
      if (set_accept_int && (bus.set_index == idx)) begin
        pend = 1'b1;
        tag  = bus.set_tag;
      end
`endif
      if (idx == '0) begin
        pend = 1'b0;
        tag  = '0;
      end
    end

    assign read_pending_vec[gi]             = pend;
    assign read_tag_vec[gi*WIDTH +: WIDTH]  = tag;
  end

  assign bus.read_pending  = read_pending_vec;
  assign bus.read_tag      = read_tag_vec;
  assign bus.set_accept    = set_accept_int;
  assign bus.pending_count = count_reg;
  assign bus.full          = full_int;

endmodule
